// File: rtl/knn_pkg.sv
// Shared KNN definitions: classifier constants, scheduler defaults and FSM state encoding.
package knn_pkg;

    localparam int LABELS       = 10;
    localparam int K_NEIGHBOURS = 4;
    localparam int N_MAX_DEF    = 64;
    localparam int M_MAX_DEF    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_RESULT = 3'd3,
        ST_FINISH = 3'd4
    } sched_state_t;

endpackage

// File: rtl/knn_idx_cnt.sv
// Wrapping index counter: zero load, increment, and a terminal-count flag against a runtime limit.
module knn_idx_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         tc
);

    logic [W-1:0] idx_reg;

    assign idx = idx_reg;
    assign tc  = (idx_reg == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg <= '0;
        end else if (load) begin
            idx_reg <= '0;
        end else if (inc) begin
            idx_reg <= tc ? '0 : idx_reg + W'(1);
        end
    end

endmodule

// File: rtl/knn_sched.sv
// KNN scheduler: walks every training point for each test point, handshaking pairs into the
// distance datapath and each finished K-list out to the result consumer.
module knn_sched
    import knn_pkg::*;
#(
    parameter int N_MAX = N_MAX_DEF,
    parameter int M_MAX = M_MAX_DEF,
    localparam int NW   = $clog2(N_MAX),
    localparam int MW   = $clog2(M_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [NW:0]   n_points,
    input  logic [MW:0]   m_points,
    output logic [NW-1:0] trn_idx,
    output logic [MW-1:0] tst_idx,
    output logic          dp_valid,
    input  logic          dp_ready,
    output logic          dp_first,
    input  logic          dp_done,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [NW:0] N_CAP = (NW+1)'(N_MAX);
    localparam logic [MW:0] M_CAP = (MW+1)'(M_MAX);

    sched_state_t state_reg, state_next;
    logic [NW:0]  n_lat_reg;
    logic [MW:0]  m_lat_reg;
    logic [NW:0]  n_sat, n_m1;
    logic [MW:0]  m_sat, m_m1;
    logic         start_go, trn_inc, tst_inc, trn_tc, tst_tc;

    assign n_sat = (n_points > N_CAP) ? N_CAP : n_points;
    assign m_sat = (m_points > M_CAP) ? M_CAP : m_points;
    assign n_m1  = n_lat_reg - (NW+1)'(1);
    assign m_m1  = m_lat_reg - (MW+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            n_lat_reg <= '0;
            m_lat_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_go) begin
                n_lat_reg <= n_sat;
                m_lat_reg <= m_sat;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        start_go   = 1'b0;
        trn_inc    = 1'b0;
        tst_inc    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    start_go   = 1'b1;
                    state_next = (n_sat == '0 || m_sat == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dp_ready) begin
                    trn_inc = 1'b1;
                    if (trn_tc) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (dp_done) state_next = ST_RESULT;
            end
            ST_RESULT: begin
                if (res_ready) begin
                    if (tst_tc) begin
                        state_next = ST_FINISH;
                    end else begin
                        tst_inc    = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // Abort overrides any transfer or handshake completing in the same cycle.
        if (abort && state_reg != ST_IDLE) begin
            state_next = ST_IDLE;
            trn_inc    = 1'b0;
            tst_inc    = 1'b0;
        end
    end

    knn_idx_cnt #(.W(NW)) u_trn_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_go),
        .inc   (trn_inc),
        .last  (n_m1[NW-1:0]),
        .idx   (trn_idx),
        .tc    (trn_tc)
    );

    knn_idx_cnt #(.W(MW)) u_tst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_go),
        .inc   (tst_inc),
        .last  (m_m1[MW-1:0]),
        .idx   (tst_idx),
        .tc    (tst_tc)
    );

    assign dp_valid  = (state_reg == ST_ISSUE);
    assign dp_first  = dp_valid && (trn_idx == '0);
    assign res_valid = (state_reg == ST_RESULT);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_FINISH);

endmodule

// File: tb/tb_knn_sched.sv
// Self-checking bench for knn_sched: table-driven runs plus directed stall, abort and reset sequences.
module tb_knn_sched;

    localparam int NW = 6;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, res_ready;
    logic [NW:0]   n_points;
    logic [MW:0]   m_points;
    logic [NW-1:0] trn_idx;
    logic [MW-1:0] tst_idx;
    logic          dp_valid, dp_first, res_valid, busy, done, dp_done;
    bit            dp_ready, tog, auto_done, man_done;

    typedef struct { int trn; int tst; int first; } pair_t;
    typedef struct { int n; int m; int rmode; int exp_xfers; } vec_t;

    pair_t exp_pairs[$];
    int    exp_res[$];
    int    n_checks = 0, n_err = 0;
    int    done_cnt = 0, xfer_cnt = 0, valid_cnt = 0;
    int    cur_last = 0, rdy_mode = 0, dd_cnt = 0;
    bit    auto_en = 1'b1;
    bit    stall_prev = 1'b0;
    int    s_trn, s_tst, s_first;

    always #5 clk = ~clk;
    assign dp_done = auto_done | man_done;

    knn_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .n_points  (n_points),
        .m_points  (m_points),
        .trn_idx   (trn_idx),
        .tst_idx   (tst_idx),
        .dp_valid  (dp_valid),
        .dp_ready  (dp_ready),
        .dp_first  (dp_first),
        .dp_done   (dp_done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // dp_ready pattern: mode 0 holds it high, mode 1 alternates every cycle.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) dp_ready = 1'b1;
        else begin
            tog      = ~tog;
            dp_ready = tog;
        end
    end

    // Datapath model: dp_done pulses two cycles after the last pair of a test point transfers.
    always @(negedge clk) begin
        auto_done = 1'b0;
        if (!rst_n) dd_cnt = 0;
        else begin
            if (dd_cnt > 0) begin
                dd_cnt--;
                if (dd_cnt == 0) auto_done = 1'b1;
            end
            if (auto_en && dp_valid && dp_ready && !abort && int'(trn_idx) == cur_last) dd_cnt = 2;
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        pair_t p;
        int    r;
        if (!rst_n) stall_prev = 1'b0;
        else begin
            if (dp_valid) valid_cnt++;
            if (done) done_cnt++;
            if (stall_prev && dp_valid) begin
                chk("stall_trn", int'(trn_idx), s_trn);
                chk("stall_tst", int'(tst_idx), s_tst);
                chk("stall_first", int'(dp_first), s_first);
            end
            stall_prev = dp_valid && !dp_ready && !abort;
            s_trn = int'(trn_idx); s_tst = int'(tst_idx); s_first = int'(dp_first);
            if (dp_valid && dp_ready && !abort) begin
                xfer_cnt++;
                if (exp_pairs.size() == 0) chk("extra_pair", 1, 0);
                else begin
                    p = exp_pairs.pop_front();
                    chk("pair_trn", int'(trn_idx), p.trn);
                    chk("pair_tst", int'(tst_idx), p.tst);
                    chk("pair_first", int'(dp_first), p.first);
                end
            end
            if (res_valid && res_ready && !abort) begin
                if (exp_res.size() == 0) chk("extra_result", 1, 0);
                else begin
                    r = exp_res.pop_front();
                    chk("result_tst", int'(tst_idx), r);
                end
            end
        end
    end

    task automatic push_run(input int ns, input int ms);
        for (int t = 0; t < ms; t++) begin
            for (int i = 0; i < ns; i++) exp_pairs.push_back('{i, t, (i == 0) ? 1 : 0});
            if (ns > 0) exp_res.push_back(t);
        end
    endtask

    task automatic pulse_start(input int n, input int m);
        @(posedge clk); #1;
        n_points = (NW+1)'(n); m_points = (MW+1)'(m); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n_points = (NW+1)'(1); m_points = (MW+1)'(1);
    endtask

    task automatic wait_done(input int base, input string name);
        int k = 0;
        while (done_cnt == base && k < 2000) begin
            @(negedge clk); k++;
        end
        chk({name, "_timeout"}, (k < 2000) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
        chk({name, "_done_pulses"}, done_cnt - base, 1);
        chk({name, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic run_case(input int n, input int m, input int rmode, input int exp_x);
        int ns, ms, base_d, base_x;
        ns = (n > 64) ? 64 : n;
        ms = (m > 8) ? 8 : m;
        rdy_mode = rmode; cur_last = ns - 1;
        push_run(ns, ms);
        base_d = done_cnt; base_x = xfer_cnt;
        pulse_start(n, m);
        wait_done(base_d, "run");
        chk("run_xfers", xfer_cnt - base_x, exp_x);
        chk("run_pairs_left", exp_pairs.size(), 0);
        chk("run_res_left", exp_res.size(), 0);
        $display("case n=%0d m=%0d ready_mode=%0d transfers=%0d", n, m, rmode, xfer_cnt - base_x);
    endtask

    task automatic zero_case(input int n, input int m);
        int base_d, base_v, busy_cyc, done_at;
        base_d = done_cnt; base_v = valid_cnt; busy_cyc = 0; done_at = -1;
        pulse_start(n, m);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done && done_at < 0) done_at = j;
        end
        chk("zero_done_pulses", done_cnt - base_d, 1);
        chk("zero_done_in_window", (done_at >= 0 && done_at <= 1) ? 1 : 0, 1);
        chk("zero_busy_cycles", busy_cyc, done_at + 1);
        chk("zero_no_valid", valid_cnt - base_v, 0);
        $display("zero case n=%0d m=%0d done_at=%0d busy_cycles=%0d", n, m, done_at, busy_cyc);
    endtask

    initial begin
        vec_t vt[6];
        int   base_d, k;

        vt[0] = '{4, 2, 0, 8};
        vt[1] = '{3, 1, 1, 3};
        vt[2] = '{1, 1, 0, 1};
        vt[3] = '{5, 3, 1, 15};
        vt[4] = '{70, 1, 0, 64};
        vt[5] = '{2, 9, 0, 16};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        n_points = '0; m_points = '0;
        repeat (2) @(negedge clk);
        chk("rst_trn", int'(trn_idx), 0);
        chk("rst_tst", int'(tst_idx), 0);
        chk("rst_valid", int'(dp_valid), 0);
        chk("rst_first", int'(dp_first), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_case(vt[i].n, vt[i].m, vt[i].rmode, vt[i].exp_xfers);

        zero_case(0, 2);
        zero_case(3, 0);

        // Consumer back-pressure, with a start request that must be ignored while busy.
        rdy_mode = 0; cur_last = 1; res_ready = 1'b0;
        push_run(2, 2);
        base_d = done_cnt;
        pulse_start(2, 2);
        k = 0;
        while (!res_valid && k < 50) begin @(negedge clk); k++; end
        chk("hold_res_seen", int'(res_valid), 1);
        @(posedge clk); #1; n_points = (NW+1)'(1); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("hold_res_valid", int'(res_valid), 1);
            chk("hold_no_issue", int'(dp_valid), 0);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        wait_done(base_d, "hold");
        chk("hold_pairs_left", exp_pairs.size(), 0);
        chk("hold_res_left", exp_res.size(), 0);
        $display("back-pressure case done_pulses=%0d", done_cnt - base_d);

        // Abort in ISSUE at trn_idx 2 while the pair would otherwise transfer.
        rdy_mode = 0; cur_last = 3;
        exp_pairs.push_back('{0, 0, 1});
        exp_pairs.push_back('{1, 0, 0});
        base_d = done_cnt;
        pulse_start(4, 1);
        k = 0;
        while (!(dp_valid && trn_idx == 2) && k < 50) begin @(posedge clk); #1; k++; end
        chk("abort_reach_trn2", (k < 50) ? 1 : 0, 1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(dp_valid), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt - base_d, 0);
        chk("abort_pairs_left", exp_pairs.size(), 0);
        $display("abort case done_pulses=%0d", done_cnt - base_d);
        run_case(2, 1, 0, 2);

        // Reset during DRAIN, then a stray dp_done after release.
        auto_en = 1'b0; rdy_mode = 0; cur_last = 1;
        exp_pairs.push_back('{0, 0, 1});
        exp_pairs.push_back('{1, 0, 0});
        base_d = done_cnt;
        pulse_start(2, 1);
        k = 0;
        while (!(busy && !dp_valid && !res_valid) && k < 50) begin @(posedge clk); #1; k++; end
        chk("rst_reach_drain", (k < 50) ? 1 : 0, 1);
        rst_n = 1'b0;
        #2;
        chk("midrst_trn", int'(trn_idx), 0);
        chk("midrst_tst", int'(tst_idx), 0);
        chk("midrst_valid", int'(dp_valid), 0);
        chk("midrst_res_valid", int'(res_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 man_done = 1'b1;
        @(posedge clk); #1 man_done = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("postrst_busy", int'(busy), 0);
            chk("postrst_res_valid", int'(res_valid), 0);
            chk("postrst_valid", int'(dp_valid), 0);
        end
        chk("postrst_no_done", done_cnt - base_d, 0);
        chk("postrst_pairs_left", exp_pairs.size(), 0);
        $display("reset-in-drain case done_pulses=%0d", done_cnt - base_d);
        auto_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
